mcht_rx_dec: RTL
================

MCHT_RX_DEC -- requirements
Module: mcht_rx_dec

Interface
REQ-001 The block SHALL provide parameter BIT_CLKS, default 16, giving clk cycles per Manchester bit; it SHALL be a multiple of 4 and at least 8.
REQ-002 The clk port SHALL be an input of width 1 and is the single clock.
REQ-003 The rst_n port SHALL be an input of width 1 and is the asynchronous, active-low reset.
REQ-004 The ena port SHALL be an input of width 1 and is the design-selected enable.
REQ-005 The rx_i port SHALL be an input of width 1 carrying the asynchronous serial line, which idles low.
REQ-006 The out_data port SHALL be an output of width 8 carrying the decoded byte.
REQ-007 The out_valid port SHALL be an output of width 1 indicating that the byte is available.
REQ-008 The out_ready port SHALL be an input of width 1 through which the consumer accepts the byte.
REQ-009 The frm_err port SHALL be an output of width 1 giving a 1-cycle pulse on a timing or parity error.
REQ-010 The ovf port SHALL be an output of width 1 giving a sticky overflow flag.
REQ-011 The ovf_clr port SHALL be an input of width 1 that clears ovf.

Function
REQ-012 rx_i SHALL pass through a 2-flop synchronizer followed by an edge-detect register, giving 3 cycles of total edge latency.
REQ-013 Bit coding SHALL be as follows:
- A rising mid-bit edge SHALL decode as 1.
- A falling mid-bit edge SHALL decode as 0.
- Bytes SHALL be sent MSB first.
REQ-014 The frame SHALL consist of a start bit (1), then 8 data bits, then an optional parity bit (REQ-028), then a return to idle low.
REQ-015 The state machine SHALL have states IDLE, DATA and ERR.
REQ-016 In IDLE, a rising edge SHALL be taken as the start-bit mid-edge: the bit counter SHALL clear, the window counter SHALL clear, and the state SHALL go to DATA.
REQ-017 In IDLE, a falling edge SHALL be ignored; this covers the return-to-idle after a trailing 1.
REQ-018 In DATA, the window counter SHALL increment every cycle and clear on each accepted mid-bit edge.
REQ-019 In DATA, edge classification SHALL be by window count:
- An edge at count < 3*BIT_CLKS/4 is a boundary edge and SHALL be ignored.
- An edge at count 3*BIT_CLKS/4 to 5*BIT_CLKS/4-1 inclusive is a mid-bit edge and SHALL shift its polarity bit into the shift register.
REQ-020 In DATA, if the window count reaches 5*BIT_CLKS/4 with no mid-bit edge, the state SHALL go to ERR.
REQ-021 ERR SHALL assert frm_err for exactly 1 cycle, discard the partial byte, and return to IDLE on the next cycle.
REQ-022 On the last data mid-bit edge (or the parity edge when REQ-028 applies), the byte SHALL be delivered and the state SHALL return to IDLE.
- out_valid SHALL assert exactly 3 cycles after the clk edge that first samples that rx_i transition.
REQ-023 The output handshake SHALL work as follows:
- out_data SHALL be stable while out_valid=1.
- The byte transfers on a cycle with out_valid=1 and out_ready=1.
- out_valid SHALL deassert on the next cycle unless a new byte completes in the same cycle, in which case the new byte SHALL load and out_valid SHALL remain 1.
REQ-024 If a byte completes while out_valid=1 and out_ready=0, the new byte SHALL be dropped, out_data SHALL be held, and ovf SHALL set.
REQ-025 ovf SHALL clear on ovf_clr=1; if set and clear occur in the same cycle, set SHALL win.
REQ-026 When ena=0, the state machine SHALL be forced to IDLE synchronously and frm_err SHALL be held 0.
- A pending out_valid SHALL remain until it is consumed.

Reset
REQ-027 While rst_n=0:
- state SHALL be IDLE.
- Counters, the shift register and the synchronizer SHALL be 0.
- out_data SHALL be 8'h00, and out_valid, frm_err and ovf SHALL be 0.
- An in-flight frame SHALL be abandoned with no frm_err pulse.

Configuration
REQ-028 With macro MCHT_RX_PARITY_EN defined:
- A 9th bit carrying even parity over the 8 data bits SHALL follow the data.
- On a parity mismatch, frm_err SHALL pulse and the byte SHALL be dropped.
- out_valid latency SHALL be measured from the parity mid-edge.
REQ-029 Without MCHT_RX_PARITY_EN, frames SHALL have 8 data bits and no parity logic SHALL exist.

Structure
REQ-030 Package mcht_pkg SHALL hold:
- the state enum (IDLE, DATA, ERR);
- BIT_CLKS_DEF = 16;
- a window-counter width function giving $clog2(5*BIT_CLKS/4 + 1).
REQ-031 Sub-module mcht_sync_edge SHALL contain the 2-flop synchronizer plus registered rise/fall pulse outputs.

Verification
REQ-032 With BIT_CLKS=16, send start + 0xA5 with out_ready=1 -> one out_valid pulse, out_data=0xA5, frm_err=0, ovf=0.
REQ-033 Send 0x3C then 0xC3 back-to-back with out_ready=0 -> out_data holds 0x3C and ovf=1; pulse ovf_clr -> ovf=0.
REQ-034 Stall the line (no edges) after 3 data bits -> frm_err is 1 for exactly 1 cycle at window count 20, state returns to IDLE, and there is no out_valid.
REQ-035 Apply mid-bit jitter of ±3 clk (window 12..19) on bytes 0x00 and 0xFF -> both decode correctly; an edge at count 11 is ignored.
REQ-036 Assert rst_n=0 mid-frame, then send 0x5A -> all outputs are 0 during reset and 0x5A decodes cleanly afterwards.
REQ-037 With MCHT_RX_PARITY_EN defined, send 0x81 with parity 0 -> delivered; send 0x81 with parity 1 -> frm_err pulses and there is no out_valid.

Source files
------------

// File: rtl/mcht_pkg.sv
// Shared types and sizing helpers for the Manchester receive decoder.
// The optional parity bit is enabled by defining MCHT_RX_PARITY_EN.
package mcht_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ERR  = 2'd2
    } state_e;

    localparam int BIT_CLKS_DEF = 16;

    // Window counter has to hold the timeout value 5*BIT_CLKS/4 itself.
    function automatic int win_cnt_w(input int bit_clks);
        return $clog2(5 * bit_clks / 4 + 1);
    endfunction

endpackage

// File: rtl/mcht_sync_edge.sv
// Two-flop synchronizer for the serial line followed by registered
// single-cycle rise/fall pulses (three clocks from line change to pulse).
module mcht_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;
    logic rise_q, fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
            fall_q <= ~s2_q & s3_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/mcht_rx_dec.sv
// Manchester receive decoder: start bit, 8 data bits MSB first, optional
// even parity bit (MCHT_RX_PARITY_EN), valid/ready byte output with overflow.
//
// state | meaning
// IDLE  | line idle, waiting for the start-bit rising mid-edge
// DATA  | timing mid-bit edges and shifting in data (and parity) bits
// ERR   | one cycle with frm_err high, partial byte discarded
module mcht_rx_dec
    import mcht_pkg::*;
#(
    parameter int BIT_CLKS = BIT_CLKS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx_i,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frm_err,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int CW = win_cnt_w(BIT_CLKS);
    localparam logic [CW-1:0] MID_LO  = CW'(3 * BIT_CLKS / 4);
    localparam logic [CW-1:0] WIN_MAX = CW'(5 * BIT_CLKS / 4);
`ifdef MCHT_RX_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd8;
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [7:0]    sh_q;
    logic [7:0]    out_data_q;
    logic          out_valid_q;
    logic          frm_err_q;
    logic          ovf_q;

    logic          rise_w, fall_w;
    logic          mid_w, last_w;
    logic          cmpl_w, perr_w;
    logic [7:0]    cbyte_w;

    mcht_sync_edge u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (rx_i),
        .rise_o (rise_w),
        .fall_o (fall_w)
    );

    assign mid_w  = (rise_w | fall_w) && (cnt_q >= MID_LO);
    assign last_w = (bit_q == LAST_BIT);

    always_comb begin
        cmpl_w  = 1'b0;
        perr_w  = 1'b0;
        cbyte_w = {sh_q[6:0], rise_w};
        if (ena && state_q == DATA && cnt_q != WIN_MAX && mid_w && last_w) begin
`ifdef MCHT_RX_PARITY_EN
            // Even parity: data bits plus parity bit must carry an even count of ones.
            cbyte_w = sh_q;
            perr_w  = ^{sh_q, rise_w};
            cmpl_w  = ~perr_w;
`else
            cmpl_w  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frm_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            // A completed byte is dropped only when the previous one is still stalled.
            if (cmpl_w && (!out_valid_q || out_ready)) begin
                out_data_q  <= cbyte_w;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (cmpl_w && out_valid_q && !out_ready) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end

            frm_err_q <= 1'b0;

            if (!ena) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise_w) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            bit_q   <= '0;
                        end
                    end
                    DATA: begin
                        if (cnt_q == WIN_MAX) begin
                            state_q   <= ERR;
                            frm_err_q <= 1'b1;
                        end else if (mid_w) begin
                            cnt_q <= '0;
                            if (last_w) begin
                                state_q   <= perr_w ? ERR : IDLE;
                                frm_err_q <= perr_w;
                            end else begin
                                sh_q  <= {sh_q[6:0], rise_w};
                                bit_q <= bit_q + 4'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ERR: begin
                        state_q <= IDLE;
                        sh_q    <= '0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frm_err   = frm_err_q;
    assign ovf       = ovf_q;

endmodule
